// File: rtl/iram_dump_tx.sv
// Reads instruction RAM back while the CPU is paused and streams every 24-bit
// word to the host as three 8N1 UART bytes, most significant byte first.
module iram_dump_tx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpu_paused,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] iram_addr,
    input  logic [23:0]       iram_data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [15:0]       word_q, word_d;
    logic [7:0]        byte_q, byte_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic              tx_q, tx_d;
    logic              baud_tick;

    assign baud_tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        word_d     = word_q;
        byte_d     = byte_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = '0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        aborted    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && cpu_paused) begin
                    end_d   = last_addr;
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // Top byte goes straight to the shifter; the lower two wait in word_q.
                word_d     = iram_data[15:0];
                byte_d     = iram_data[23:16];
                byte_idx_d = 2'd0;
                state_d    = S_START;
            end
            S_START: begin
                baud_d = baud_tick ? '0 : baud_q + CNT_W'(1);
                if (baud_tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_tick ? '0 : baud_q + CNT_W'(1);
                if (baud_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        byte_d    = {1'b0, byte_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                baud_d = baud_tick ? '0 : baud_q + CNT_W'(1);
                if (baud_tick) begin
                    if (byte_idx_q != 2'd2) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        byte_d     = (byte_idx_q == 2'd0) ? word_q[15:8] : word_q[7:0];
                        state_d    = S_START;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                // Compare before incrementing so end=all-ones never wraps to 0.
                if (!cpu_paused) begin
                    aborted = 1'b1;
                    busy    = 1'b0;
                    state_d = S_IDLE;
                end else if (addr_q == end_q) begin
                    done    = 1'b1;
                    busy    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Line level is registered from the next state so tx changes in step with it.
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = byte_d[0];
        end else begin
            tx_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
        byte_q <= byte_d;
    end

    assign iram_addr = addr_q;
    assign tx        = tx_q;

endmodule

// File: tb/tb_iram_dump_tx.sv
// Directed bench for iram_dump_tx: a UART receiver model decodes tx and compares
// every byte against the word stream expected from the bench's own iRAM image.
module tb_iram_dump_tx;

    // 18/4 truncates to 4 clocks per bit; one word costs 3 + 30*4 = 123 cycles.
    localparam int CLK_FREQ = 18;
    localparam int BAUD     = 4;
    localparam int CPB      = 4;
    localparam int WORD_CYC = 123;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cpu_paused;
    logic [7:0]  last_addr;
    logic [7:0]  iram_addr;
    logic [23:0] iram_data;
    logic        tx;
    logic        busy;
    logic        done;
    logic        aborted;

    logic [23:0] mem [256];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_log [$];
    logic [7:0]  addr_log [$];
    logic        rx_clear;

    iram_dump_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .ADDR_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cpu_paused(cpu_paused),
        .last_addr (last_addr),
        .iram_addr (iram_addr),
        .iram_data (iram_data),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        iram_data <= mem[iram_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [23:0] w);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // UART receiver: samples mid-bit, compares each completed byte with the expected stream.
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        int n;
        n = rx_cnt + 1;
        if (rx_clear) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 0;
            end
        end else begin
            rx_cnt <= n;
            if (n == CPB / 2) begin
                check("rx_start_bit", int'(tx), 0);
            end else if (n < 9 * CPB + CPB / 2 && (n % CPB) == CPB / 2) begin
                rx_sh <= {tx, rx_sh[7:1]};
            end else if (n == 9 * CPB + CPB / 2) begin
                check("rx_stop_bit", int'(tx), 1);
                rx_log.push_back(rx_sh);
                if (exp_q.size() == 0) begin
                    check("rx_unexpected_byte", int'(rx_sh), -1);
                end else begin
                    check("rx_byte", int'(rx_sh), int'(exp_q.pop_front()));
                end
                rx_busy <= 1'b0;
            end
        end
    end

    // Per-cycle output rules plus a log of each address presented while busy.
    logic       prev_busy = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) check("tx_idle_high", int'(tx), 1);
            if (done || aborted) begin
                check("pulse_while_busy", int'(busy), 0);
                check("done_and_aborted", int'(done & aborted), 0);
            end
            if (done) done_cnt <= done_cnt + 1;
            if (aborted) abort_cnt <= abort_cnt + 1;
            if (busy && (!prev_busy || iram_addr != prev_addr)) addr_log.push_back(iram_addr);
        end
        prev_busy <= busy;
        prev_addr <= iram_addr;
    end

    task automatic pulse_start(input logic [7:0] la, output int scyc);
        @(negedge clk);
        last_addr = la;
        start     = 1'b1;
        scyc      = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int ecyc, output int got_done,
                            output int got_abort);
        ecyc      = -1;
        got_done  = 0;
        got_abort = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || aborted) begin
                ecyc      = cyc;
                got_done  = int'(done);
                got_abort = int'(aborted);
                break;
            end
        end
        if (ecyc < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_end: no done/aborted within %0d cycles", budget);
        end
    endtask

    task automatic wait_addr(input logic [7:0] a, input int budget);
        int hit;
        hit = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (iram_addr == a) begin
                hit = 1;
                break;
            end
        end
        check("wait_addr_reached", hit, 1);
    endtask

    task automatic clear_logs();
        rx_log.delete();
        addr_log.delete();
        exp_q.delete();
    endtask

    logic [7:0] mw_exp [9] = '{8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        int s, e, gd, ga, d0, a0, s2, bad;
        rst        = 1'b1;
        start      = 1'b0;
        cpu_paused = 1'b1;
        last_addr  = 8'h00;
        rx_clear   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;

        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_aborted", int'(aborted), 0);
        check("reset_addr", int'(iram_addr), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word.
        mem[0] = 24'hA1B2C3;
        clear_logs();
        push_word(mem[0]);
        d0 = done_cnt;
        pulse_start(8'd0, s);
        wait_end(WORD_CYC + 40, e, gd, ga);
        check("single_latency", e - s, 123);
        check("single_done", gd, 1);
        check("single_aborted", ga, 0);
        repeat (4) @(negedge clk);
        check("single_busy_after", int'(busy), 0);
        check("single_nbytes", rx_log.size(), 3);
        check("single_b0", int'(rx_log[0]), 32'hA1);
        check("single_b1", int'(rx_log[1]), 32'hB2);
        check("single_b2", int'(rx_log[2]), 32'hC3);
        check("single_done_count", done_cnt - d0, 1);
        check("single_exp_left", exp_q.size(), 0);

        // Multi-word.
        mem[0] = 24'h000001;
        mem[1] = 24'h800000;
        mem[2] = 24'hFFFFFF;
        clear_logs();
        for (int i = 0; i < 3; i++) push_word(mem[i]);
        d0 = done_cnt;
        pulse_start(8'd2, s);
        wait_end(3 * WORD_CYC + 40, e, gd, ga);
        check("multi_latency", e - s, 369);
        check("multi_done", gd, 1);
        repeat (4) @(negedge clk);
        check("multi_nbytes", rx_log.size(), 9);
        for (int i = 0; i < 9; i++) check("multi_byte", int'(rx_log[i]), int'(mw_exp[i]));
        check("multi_naddr", addr_log.size(), 3);
        for (int i = 0; i < 3; i++) check("multi_addr_seq", int'(addr_log[i]), i);
        check("multi_done_count", done_cnt - d0, 1);
        check("multi_exp_left", exp_q.size(), 0);

        // Start ignored while the CPU runs.
        clear_logs();
        cpu_paused = 1'b0;
        pulse_start(8'd0, s);
        repeat (20) @(negedge clk);
        check("gate_busy", int'(busy), 0);
        check("gate_tx", int'(tx), 1);
        check("gate_nbytes", rx_log.size(), 0);
        cpu_paused = 1'b1;
        repeat (2) @(negedge clk);

        // Second start during a dump must not restart it or change its end.
        mem[0] = 24'h123456;
        mem[1] = 24'h89ABCD;
        clear_logs();
        push_word(mem[0]);
        push_word(mem[1]);
        d0 = done_cnt;
        pulse_start(8'd1, s);
        repeat (50) @(negedge clk);
        pulse_start(8'd5, s2);
        wait_end(2 * WORD_CYC + 40, e, gd, ga);
        check("restart_latency", e - s, 246);
        check("restart_done", gd, 1);
        repeat (4) @(negedge clk);
        check("restart_nbytes", rx_log.size(), 6);
        check("restart_naddr", addr_log.size(), 2);
        check("restart_done_count", done_cnt - d0, 1);
        check("restart_exp_left", exp_q.size(), 0);

        // Abort: cpu_paused falls in the middle of word 1, byte 1.
        for (int i = 0; i < 4; i++) mem[i] = 24'h5A0000 | 24'(i);
        clear_logs();
        push_word(mem[0]);
        push_word(mem[1]);
        d0 = done_cnt;
        a0 = abort_cnt;
        pulse_start(8'd3, s);
        wait_addr(8'd1, WORD_CYC + 20);
        repeat (CPB * 15) @(negedge clk);
        cpu_paused = 1'b0;
        wait_end(2 * WORD_CYC + 40, e, gd, ga);
        check("abort_latency", e - s, 246);
        check("abort_flag", ga, 1);
        check("abort_done", gd, 0);
        repeat (4) @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_tx", int'(tx), 1);
        check("abort_nbytes", rx_log.size(), 6);
        check("abort_done_count", done_cnt - d0, 0);
        check("abort_count", abort_cnt - a0, 1);
        check("abort_exp_left", exp_q.size(), 0);
        cpu_paused = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the data bits of word 1.
        for (int i = 0; i < 3; i++) mem[i] = 24'hC0FFEE;
        clear_logs();
        for (int i = 0; i < 3; i++) push_word(mem[i]);
        pulse_start(8'd2, s);
        wait_addr(8'd1, WORD_CYC + 20);
        repeat (2 + CPB * 3) @(negedge clk);
        rst      = 1'b1;
        rx_clear = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        a0 = abort_cnt;
        @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_addr", int'(iram_addr), 0);
        check("rst_done", int'(done), 0);
        check("rst_aborted", int'(aborted), 0);
        rst = 1'b0;
        @(negedge clk);
        rx_clear = 1'b0;
        repeat (3 * WORD_CYC) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_abort", abort_cnt - a0, 0);
        check("rst_idle_busy", int'(busy), 0);
        check("rst_nbytes", rx_log.size(), 3);

        // Full depth: 256 words of {i, ~i, i}.
        for (int i = 0; i < 256; i++) mem[i] = {i[7:0], ~i[7:0], i[7:0]};
        clear_logs();
        for (int i = 0; i < 256; i++) push_word(mem[i]);
        d0 = done_cnt;
        pulse_start(8'd255, s);
        wait_end(256 * WORD_CYC + 100, e, gd, ga);
        check("full_latency", e - s, 31488);
        check("full_done", gd, 1);
        repeat (4) @(negedge clk);
        check("full_nbytes", rx_log.size(), 768);
        check("full_last0", int'(rx_log[765]), 32'hFF);
        check("full_last1", int'(rx_log[766]), 32'h00);
        check("full_last2", int'(rx_log[767]), 32'hFF);
        check("full_done_count", done_cnt - d0, 1);
        check("full_end_addr", int'(iram_addr), 255);
        check("full_naddr", addr_log.size(), 256);
        bad = 0;
        for (int i = 0; i < addr_log.size(); i++) if (int'(addr_log[i]) != i) bad++;
        check("full_addr_seq_errors", bad, 0);
        check("full_exp_left", exp_q.size(), 0);
        check("full_busy_after", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iram_dump_tx.md
Name: iram_dump_tx

Overview:
UART transmitter that reads back instruction RAM while the CPU is paused and streams every word to the host for flash verification. It is the return path of the UART instruction-loading chain: the loader writes iRAM, and this block reads it out. It drives the shared iRAM address mux while dumping and serialises each 24-bit word as three 8N1 bytes.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 868 at defaults)
ADDR_W, 8, iRAM address width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a dump
cpu_paused  input  1  high while the CPU is halted for loading/debug; a dump may run only while this is high
last_addr  input  8  final iRAM address to send, inclusive; sampled on start
iram_addr  output  8  read address to iRAM; the top-level mux selects it while busy
iram_data  input  24  iRAM read data, valid one clk after iram_addr changes
tx  output  1  UART serial out, idle high
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-cycle pulse after the last byte's stop bit completes
aborted  output  1  one-cycle pulse when a dump ends early because cpu_paused fell

Behaviour:
- Reset values: tx=1, busy=0, done=0, aborted=0, iram_addr=0, state=IDLE, all counters 0. rst mid-frame takes effect next edge; tx returns high immediately, with no partial-byte completion.
- States: IDLE, FETCH, LATCH, START, DATA, STOP, NEXT.
- IDLE: start && cpu_paused -> latch end=last_addr, iram_addr=0, busy=1, go to FETCH. start while !cpu_paused or while busy is ignored.
- FETCH: wait exactly one cycle for read latency -> LATCH.
- LATCH: shift_word <= iram_data, byte_idx=0, load byte = shift_word[23:16] -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx<2: byte_idx++, next byte ([15:8], then [7:0]) -> START.
  - else -> NEXT.
- Byte order per word: MSB byte first. One word = 30 bit-times; there are no idle gaps between bytes.
- NEXT:
  - if !cpu_paused: aborted=1 for one cycle, busy=0 -> IDLE.
  - else if iram_addr==end: done=1 for one cycle, busy=0 -> IDLE.
  - else iram_addr++ -> FETCH.
- Abort check happens only at word boundaries. A byte or word in flight always completes, so the host never sees a truncated frame.
- end=255 sends 256 words. The comparison happens before increment, so iram_addr never wraps to 0 and re-sends.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change. Bit timing is exact; there is no drift across bytes.
- iram_addr holds its value from FETCH through NEXT. It changes only in IDLE (on start) and in NEXT.
- done and aborted are mutually exclusive and never assert in the same cycle as busy=1.
- start in the same cycle as the done/aborted pulse is ignored, because state is not yet IDLE.

Test Plan:
- Reset: assert rst during DATA -> next cycle tx=1, busy=0, iram_addr=0; no done or aborted.
- Single word (CLK_FREQ=16, BAUD=1, so 16 clk/bit), cpu_paused=1, last_addr=0, iRAM[0]=0xA1B2C3, pulse start -> bytes A1,B2,C3 decoded LSB-first with 8N1 framing. done pulses 1+1+480+1 cycles after start (±1), then busy=0.
- Multi-word: last_addr=2, iRAM[0..2]=0x000001,0x800000,0xFFFFFF -> byte stream 00 00 01 80 00 00 FF FF FF; iram_addr sequence 0,1,2; single done.
- Full depth: last_addr=255, iRAM[i]={i,~i,i} -> exactly 768 bytes, final bytes FF 00 FF, done once, iram_addr ends at 255 with no wrap to 0.
- Abort: cpu_paused drops mid-byte of word 1 -> word 1 finishes all 3 bytes, then aborted pulses, done stays 0, busy=0, tx=1.
- Gating: start with cpu_paused=0 -> busy stays 0 and tx stays 1. A second start during busy -> no restart, stream unchanged.
